// File: rtl/key_event_gen.sv
// Key event generator: debounced press, long-press and idle-timeout pulses from one-hot keys.
// Define KEY_AUTO_REPEAT_EN to add the REPEAT state (periodic KEY_PRESS after KEY_LONG).
module key_event_gen #(
  parameter int NUM_KEYS     = 5,
  parameter int DEBOUNCE_CYC = 23000,
  parameter int HOLD_CYC     = 1000000,
  parameter int REPEAT_CYC   = 250000,
  parameter int TIMEOUT_CYC  = 10000000
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic                TIMEOUT_ARM,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_LONG,
  output logic [NUM_KEYS-1:0] KEY_HELD,
  output logic                IDLE_TIMEOUT,
  output logic                BUSY
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_CD  = (REPEAT_CYC > TIMEOUT_CYC) ? REPEAT_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TO_SAT    = CW'(TIMEOUT_CYC);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
`ifdef KEY_AUTO_REPEAT_EN
    , S_REPEAT
`endif
  } state_t;

  state_t                state_reg;
  logic [NUM_KEYS-1:0]   ksel_reg;
  logic [CW-1:0]         cnt_reg;
  logic [CW-1:0]         tcnt_reg;
  logic [NUM_KEYS-1:0]   press_reg;
  logic [NUM_KEYS-1:0]   long_reg;
  logic                  timeout_reg;
  logic                  key_one_hot;
  logic                  held_state;

  assign key_one_hot = ($countones(KEY) == 1);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg <= S_IDLE;
      ksel_reg  <= '0;
      cnt_reg   <= '0;
      press_reg <= '0;
      long_reg  <= '0;
    end else begin
      press_reg <= '0;
      long_reg  <= '0;
      case (state_reg)
        S_IDLE: begin
          if (key_one_hot) begin
            ksel_reg  <= KEY;
            cnt_reg   <= '0;
            state_reg <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (KEY != ksel_reg) begin
            ksel_reg  <= '0;
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else if (cnt_reg == DEB_LAST) begin
            press_reg <= ksel_reg;
            cnt_reg   <= '0;
            state_reg <= S_PRESSED;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_PRESSED: begin
          if (KEY != ksel_reg) begin
            cnt_reg   <= '0;
            state_reg <= S_RELEASE;
          end else if (cnt_reg == HOLD_LAST) begin
            long_reg <= ksel_reg;
`ifdef KEY_AUTO_REPEAT_EN
            cnt_reg   <= '0;
            state_reg <= S_REPEAT;
`else
            // park one past the threshold so the long event cannot fire again
            cnt_reg <= HOLD_SAT;
`endif
          end else if (cnt_reg != HOLD_SAT) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`ifdef KEY_AUTO_REPEAT_EN
        S_REPEAT: begin
          if (KEY != ksel_reg) begin
            cnt_reg   <= '0;
            state_reg <= S_RELEASE;
          end else if (cnt_reg == REP_LAST) begin
            press_reg <= ksel_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`endif
        S_RELEASE: begin
          if (KEY != '0) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            ksel_reg  <= '0;
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Inactivity timer: counts armed IDLE cycles, pauses while busy, saturates after firing.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tcnt_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (!TIMEOUT_ARM || (press_reg != '0)) begin
        tcnt_reg <= '0;
      end else if (state_reg == S_IDLE) begin
        if (tcnt_reg == TO_LAST) begin
          timeout_reg <= 1'b1;
          tcnt_reg    <= TO_SAT;
        end else if (tcnt_reg != TO_SAT) begin
          tcnt_reg <= tcnt_reg + CW'(1);
        end
      end
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  assign held_state = (state_reg == S_PRESSED) || (state_reg == S_REPEAT);
`else
  assign held_state = (state_reg == S_PRESSED);
`endif

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_held
    assign KEY_HELD[gi] = held_state & ksel_reg[gi];
  end

  assign KEY_PRESS    = press_reg;
  assign KEY_LONG     = long_reg;
  assign IDLE_TIMEOUT = timeout_reg;
  assign BUSY         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen with DEBOUNCE=4, HOLD=20, REPEAT=5, TIMEOUT=50, 5 keys.
module tb_key_event_gen;

  logic       CLK;
  logic       RESETN;
  logic [4:0] KEY;
  logic       TIMEOUT_ARM;
  logic [4:0] KEY_PRESS;
  logic [4:0] KEY_LONG;
  logic [4:0] KEY_HELD;
  logic       IDLE_TIMEOUT;
  logic       BUSY;

  key_event_gen #(
    .NUM_KEYS(5), .DEBOUNCE_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(5), .TIMEOUT_CYC(50)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .KEY(KEY), .TIMEOUT_ARM(TIMEOUT_ARM),
    .KEY_PRESS(KEY_PRESS), .KEY_LONG(KEY_LONG), .KEY_HELD(KEY_HELD),
    .IDLE_TIMEOUT(IDLE_TIMEOUT), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // cyc = number of rising edges so far; an output seen at a falling edge came from edge cyc-1
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int edge_idx;
    int kind;
    int val;
  } ev_t;
  ev_t exp_q[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic string kname(input int kind);
    case (kind)
      0:       return "press";
      1:       return "long";
      default: return "timeout";
    endcase
  endfunction

  task automatic push_ev(input int e, input int kind, input int val);
    ev_t ev;
    ev.edge_idx = e;
    ev.kind     = kind;
    ev.val      = val;
    exp_q.push_back(ev);
  endtask

  task automatic sb_pop(input int kind, input int val);
    ev_t e;
    int  now_e;
    now_e = cyc - 1;
    if (exp_q.size() == 0) begin
      check_val($sformatf("unexpected_%s_at_%0d", kname(kind), now_e), val, 0);
    end else begin
      e = exp_q.pop_front();
      $display("[TB] %s at edge %0d val %0d (expected %s at %0d val %0d)",
               kname(kind), now_e, val, kname(e.kind), e.edge_idx, e.val);
      check_val($sformatf("%s_kind", kname(kind)), kind, e.kind);
      check_val($sformatf("%s_edge", kname(kind)), now_e, e.edge_idx);
      check_val($sformatf("%s_val", kname(kind)), val, e.val);
    end
  endtask

  always @(negedge CLK) begin
    if (RESETN) begin
      if (KEY_PRESS != '0 && KEY_LONG != '0)
        check_val("press_long_same_cycle", 1, 0);
      if (KEY_PRESS != '0)   sb_pop(0, int'(KEY_PRESS));
      if (KEY_LONG != '0)    sb_pop(1, int'(KEY_LONG));
      if (IDLE_TIMEOUT)      sb_pop(2, 1);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_press"},   int'(KEY_PRESS), 0);
    check_val({pfx, "_long"},    int'(KEY_LONG), 0);
    check_val({pfx, "_held"},    int'(KEY_HELD), 0);
    check_val({pfx, "_timeout"}, int'(IDLE_TIMEOUT), 0);
    check_val({pfx, "_busy"},    int'(BUSY), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    RESETN = 1'b0;
    KEY = '0;
    TIMEOUT_ARM = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RESETN = 1'b1;
    repeat (2) @(negedge CLK);

    // single key held 30 cycles
    p = cyc;
    KEY = 5'b00010;
    push_ev(p + 4, 0, 2);
    push_ev(p + 24, 1, 2);
`ifdef KEY_AUTO_REPEAT_EN
    push_ev(p + 29, 0, 2);
`endif
    wait_to(p + 10);
    check_val("t1_held", int'(KEY_HELD), 2);
    check_val("t1_busy_hold", int'(BUSY), 1);
    wait_to(p + 30);
    KEY = '0;
    wait_to(p + 34);
    check_val("t1_busy_releasing", int'(BUSY), 1);
    wait_to(p + 35);
    check_val("t1_busy_idle", int'(BUSY), 0);
    check_val("t1_held_idle", int'(KEY_HELD), 0);
    wait_to(p + 40);
    check_val("t1_sb_empty", exp_q.size(), 0);

    // bounce: 3 cycles only
    p = cyc;
    KEY = 5'b00010;
    wait_to(p + 2);
    check_val("t2_busy_deb", int'(BUSY), 1);
    wait_to(p + 3);
    KEY = '0;
    wait_to(p + 5);
    check_val("t2_busy_idle", int'(BUSY), 0);
    wait_to(p + 12);

    // multi-hot ignored
    KEY = 5'b00011;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_val($sformatf("t3_busy_%0d", i), int'(BUSY), 0);
    end
    KEY = '0;
    repeat (3) @(negedge CLK);
    check_val("t3_sb_empty", exp_q.size(), 0);

    // inactivity timeout, press clears, re-arms after return to IDLE
    p = cyc;
    TIMEOUT_ARM = 1'b1;
    push_ev(p + 49, 2, 1);
    push_ev(p + 59, 0, 1);
    push_ev(p + 116, 2, 1);
    wait_to(p + 55);
    KEY = 5'b00001;
    wait_to(p + 62);
    KEY = '0;
    wait_to(p + 66);
    check_val("t4_busy_releasing", int'(BUSY), 1);
    wait_to(p + 67);
    check_val("t4_busy_idle", int'(BUSY), 0);
    wait_to(p + 125);
    TIMEOUT_ARM = 1'b0;
    check_val("t4_sb_empty", exp_q.size(), 0);

    // reset in the middle of a held press
    p = cyc;
    KEY = 5'b00100;
    push_ev(p + 4, 0, 4);
    wait_to(p + 10);
    check_val("t5_held_before", int'(KEY_HELD), 4);
    RESETN = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(negedge CLK);
    RESETN = 1'b1;
    push_ev(p + 15, 0, 4);
    wait_to(p + 14);
    check_val("t5_busy_deb", int'(BUSY), 1);
    wait_to(p + 20);
    KEY = '0;
    wait_to(p + 30);
    check_val("t5_sb_empty", exp_q.size(), 0);

    // long hold of the top key
    p = cyc;
    KEY = 5'b10000;
    push_ev(p + 4, 0, 16);
    push_ev(p + 24, 1, 16);
`ifdef KEY_AUTO_REPEAT_EN
    for (int e = p + 29; e <= p + 99; e += 5) push_ev(e, 0, 16);
`endif
    wait_to(p + 60);
    check_val("t6_held", int'(KEY_HELD), 16);
    wait_to(p + 100);
    KEY = '0;
    wait_to(p + 110);
    check_val("t6_busy_idle", int'(BUSY), 0);
    check_val("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
